// File: rtl/stack_result_tx_pkg.sv
// Shared types and sizing helpers for the stack machine result transmitter.
package stack_tx_pkg;

    localparam int unsigned WORD_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RELEASE = 2'd2
    } tx_state_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_result_tx_if.sv
// Core push bus plus host strobe/ack pins for the result transmitter.
// tx_parity exists only when STACK_TX_PARITY_EN is defined.
interface stack_result_tx_if
    import stack_tx_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
);
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_strobe;
    logic             tx_ack;
`ifdef STACK_TX_PARITY_EN
    logic             tx_parity;
`endif

    // Transmitter side
    modport master (
        input  push_valid, push_data, tx_ack,
`ifdef STACK_TX_PARITY_EN
        output tx_parity,
`endif
        output push_ready, tx_data, tx_strobe
    );

    // Core/host side
    modport slave (
        output push_valid, push_data, tx_ack,
`ifdef STACK_TX_PARITY_EN
        input  tx_parity,
`endif
        input  push_ready, tx_data, tx_strobe
    );

endinterface

// File: rtl/stack_result_tx_fifo.sv
// Circular result-byte buffer with flush and registered occupancy.
module stack_tx_fifo
    import stack_tx_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [level_w(DEPTH)-1:0]    o_level,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned LVL_W = level_w(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/stack_result_tx.sv
// Result transmitter: FIFO plus four-phase strobe/ack handshake to the host.
// Optional odd parity output enabled by STACK_TX_PARITY_EN.
module stack_result_tx
    import stack_tx_pkg::*;
#(
    parameter int unsigned WIDTH       = WORD_W,
    parameter int unsigned DEPTH       = FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       flush,
    output logic [level_w(DEPTH)-1:0]  level,
    stack_result_tx_if.master          tx_if
);

    logic [WIDTH-1:0]       w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ack_s;
    tx_state_e              r_state;
    tx_state_e              w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [WIDTH-1:0]       r_tx_data;
    logic                   r_tx_strobe;

    assign w_push           = tx_if.push_valid & ~w_full;
    assign tx_if.push_ready = ~w_full;
    assign tx_if.tx_data    = r_tx_data;
    assign tx_if.tx_strobe  = r_tx_strobe;

    stack_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_push_data (tx_if.push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_level     (level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Host ack is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tx_if.tx_ack};
        end
    end

    assign w_ack_s = r_sync[SYNC_STAGES-1];

    // Next-state; IDLE refuses to start while the host still holds ack.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (ena && !w_empty && !w_ack_s) begin
                    w_pop       = 1'b1;
                    w_state_nxt = STROBE;
                end
            end
            STROBE: begin
                if (w_ack_s) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tx_strobe <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_tx_strobe <= (w_state_nxt == STROBE);
            if (w_pop) begin
                r_tx_data <= w_head;
            end
        end
    end

`ifdef STACK_TX_PARITY_EN
    logic r_tx_parity;

    // Odd parity, loaded alongside tx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_parity <= 1'b1;
        end else if (w_pop) begin
            r_tx_parity <= ~^w_head;
        end
    end

    assign tx_if.tx_parity = r_tx_parity;
`endif

endmodule

// File: tb/tb_stack_result_tx.sv
// Directed bench for stack_result_tx: handshake, FIFO fill, flush, ena, reset.
module tb_stack_result_tx;
    import stack_tx_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       flush;
    logic [2:0] level;
    int         n_cmp;
    int         n_err;

    stack_result_tx_if #(.WIDTH(8)) bus ();

    stack_result_tx #(
        .WIDTH       (8),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .flush (flush),
        .level (level),
        .tx_if (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.push_valid = 1'b1;
        bus.push_data  = d;
        tick(1);
        bus.push_valid = 1'b0;
    endtask

    // Host side of one four-phase transfer, bounded at every wait.
    task automatic host_xfer(input string tag, input logic [7:0] exp);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.tx_strobe) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        chk({tag, "_strobe_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({tag, "_data"}, 32'(bus.tx_data), 32'(exp));
            bus.tx_ack = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 50; i++) begin
                tick(1);
                if (!bus.tx_strobe) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk({tag, "_strobe_drop"}, 32'(ok), 32'd1);
            bus.tx_ack = 1'b0;
            tick(3);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        ena   = 1'b1;
        flush = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.tx_ack     = 1'b0;
        tick(2);

        // Reset state
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(bus.push_ready), 32'd1);
        chk("rst_strobe", 32'(bus.tx_strobe), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
`ifdef STACK_TX_PARITY_EN
        chk("rst_parity", 32'(bus.tx_parity), 32'd1);
`endif
        rst_n = 1'b1;
        tick(1);

        // 1: single byte latency and ack timing
        push(8'hA5);
        chk("t1_level_after_push", 32'(level), 32'd1);
        chk("t1_strobe_early", 32'(bus.tx_strobe), 32'd0);
        tick(1);
        chk("t1_strobe_rise", 32'(bus.tx_strobe), 32'd1);
        chk("t1_data", 32'(bus.tx_data), 32'hA5);
        chk("t1_level_popped", 32'(level), 32'd0);
        tick(3);
        bus.tx_ack = 1'b1;
        tick(2);
        chk("t1_strobe_held", 32'(bus.tx_strobe), 32'd1);
        tick(1);
        chk("t1_strobe_fall", 32'(bus.tx_strobe), 32'd0);
        chk("t1_data_held", 32'(bus.tx_data), 32'hA5);
        bus.tx_ack = 1'b0;
        tick(4);

        // 2: fill the FIFO, then drain in order
        for (int i = 1; i <= 5; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 8'(i);
            tick(1);
        end
        bus.push_valid = 1'b0;
        chk("t2_level_full", 32'(level), 32'd4);
        chk("t2_ready_low", 32'(bus.push_ready), 32'd0);
        chk("t2_head_on_pins", 32'(bus.tx_data), 32'h01);
        push(8'h06);
        chk("t2_push_refused", 32'(level), 32'd4);
        for (int i = 1; i <= 5; i++) begin
            host_xfer("t2_xfer", 8'(i));
        end
        chk("t2_level_empty", 32'(level), 32'd0);
        chk("t2_ready_back", 32'(bus.push_ready), 32'd1);

        // 3: ack held across reset release blocks the first strobe
        bus.tx_ack = 1'b1;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        push(8'h3C);
        tick(4);
        chk("t3_blocked", 32'(bus.tx_strobe), 32'd0);
        chk("t3_level", 32'(level), 32'd1);
        bus.tx_ack = 1'b0;
        tick(2);
        chk("t3_still_low", 32'(bus.tx_strobe), 32'd0);
        tick(1);
        chk("t3_strobe", 32'(bus.tx_strobe), 32'd1);
        host_xfer("t3_xfer", 8'h3C);

        // 4: flush mid-STROBE with a concurrent push
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        chk("t4_level", 32'(level), 32'd2);
        chk("t4_data", 32'(bus.tx_data), 32'hAA);
        flush = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_data  = 8'hFF;
        tick(1);
        flush = 1'b0;
        bus.push_valid = 1'b0;
        chk("t4_flushed", 32'(level), 32'd0);
        chk("t4_strobe_kept", 32'(bus.tx_strobe), 32'd1);
        host_xfer("t4_xfer", 8'hAA);
        tick(10);
        chk("t4_no_ff", 32'(bus.tx_strobe), 32'd0);
        chk("t4_level_end", 32'(level), 32'd0);

        // 5: ena gating
        ena = 1'b0;
        push(8'h11);
        push(8'h22);
        tick(5);
        chk("t5_gated", 32'(bus.tx_strobe), 32'd0);
        chk("t5_level", 32'(level), 32'd2);
        ena = 1'b1;
        tick(1);
        chk("t5_resume", 32'(bus.tx_strobe), 32'd1);
        chk("t5_data", 32'(bus.tx_data), 32'h11);
        ena = 1'b0;
        host_xfer("t5_xfer1", 8'h11);
        tick(10);
        chk("t5_no_next", 32'(bus.tx_strobe), 32'd0);
        chk("t5_level_hold", 32'(level), 32'd1);
        ena = 1'b1;
        host_xfer("t5_xfer2", 8'h22);

        // 6: asynchronous reset during STROBE, then parity
        push(8'h07);
        tick(1);
        chk("t6_strobe", 32'(bus.tx_strobe), 32'd1);
        chk("t6_data", 32'(bus.tx_data), 32'h07);
`ifdef STACK_TX_PARITY_EN
        chk("t6_parity_07", 32'(bus.tx_parity), 32'd0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_strobe", 32'(bus.tx_strobe), 32'd0);
        chk("t6_async_data", 32'(bus.tx_data), 32'd0);
        chk("t6_async_level", 32'(level), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        push(8'h03);
        tick(1);
        chk("t6_data_03", 32'(bus.tx_data), 32'h03);
`ifdef STACK_TX_PARITY_EN
        chk("t6_parity_03", 32'(bus.tx_parity), 32'd1);
`endif
        host_xfer("t6_xfer", 8'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
